regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (wa3/wd3/we3) between two writeback sources: requester 0 (ALU) and requester 1 (load unit).
- Arbitration is round-robin. The winning write is registered onto the regfile write port.
- Provides hazard detection and forwarding for the two regfile read ports while a granted write is still in flight.
- Keeps saturating per-requester stall counters for performance debug.

Parameters:
- BANK_WIDTH, 5, register address width (1<<BANK_WIDTH registers).
- WIDTH, 64, register data width.
- CNT_WIDTH, 32, width of each stall counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  ALU writeback request.
- req0_addr  in  BANK_WIDTH  ALU destination register.
- req0_data  in  WIDTH  ALU result.
- req0_ready  out  1  ALU write accepted this cycle.
- req1_valid  in  1  load writeback request.
- req1_addr  in  BANK_WIDTH  load destination register.
- req1_data  in  WIDTH  load data.
- req1_ready  out  1  load write accepted this cycle.
- wa3  out  BANK_WIDTH  regfile write address (registered).
- wd3  out  WIDTH  regfile write data (registered).
- we3  out  1  regfile write enable (registered).
- ra1, ra2  in  BANK_WIDTH  addresses currently presented to the regfile read ports.
- rd1_regfile, rd2_regfile  in  WIDTH  raw regfile read data.
- rd1, rd2  out  WIDTH  read data with forwarding applied.
- hazard1, hazard2  out  1  a read port address matches the in-flight write.
- stall_cnt0, stall_cnt1  out  CNT_WIDTH  cycles each requester was valid but not ready.

Behaviour:
- Reset (rst_n low at posedge):
  - we3=0, wa3=0, wd3=0.
  - prio=0, so req0 is preferred next.
  - stall_cnt0=stall_cnt1=0.
  - While rst_n is low, req0_ready=req1_ready=0 (combinational). Reset overrides every other event in the same cycle.
- Grant logic (combinational, rst_n high):
  - Only reqN_valid high -> reqN_ready=1.
  - Both valid -> the requester selected by prio gets ready=1, the other gets 0.
  - Neither valid -> both ready=0.
  - Ready never depends on the regfile or the output register: the output stage drains every cycle, so throughput is one write per cycle.
- Handshake: a transfer happens when valid&&ready at posedge. Requesters must hold valid, addr and data stable until ready.
- prio update on a transfer: prio is set to the opposite of the granted requester, whether or not there was contention. No transfer -> prio holds.
- Output register (one-cycle latency): at the posedge of a transfer:
  - wa3 <= granted addr and wd3 <= granted data.
  - we3 <= (granted addr != 0).
  - A write to x0 is accepted (ready=1) but suppressed (we3=0).
  - No transfer -> we3 <= 0; wa3/wd3 hold.
  - The regfile commits wd3 at the posedge following acceptance.
- Forwarding (combinational):
  - hazardN = we3 && (wa3 == raN) && (raN != 0).
  - rdN = hazardN ? wd3 : rdN_regfile.
  - Both ports may hit the same in-flight write simultaneously.
- Stall counters: stall_cntN increments by 1 each cycle reqN_valid && !reqN_ready, and saturates at all-ones (no wrap).
- Simultaneous requests to the same address: both are serialized in prio order; the later grant overwrites in the regfile.
- Reset mid-operation: an in-flight write (we3=1) is dropped, because we3 clears on reset. The upstream requester must re-issue it.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ZERO, the address-0 constant.
  - A wb_req_t struct {valid, addr, data}, parameterized via package localparams BANK_WIDTH=5 and WIDTH=64.
- One natural sub-module: sat_counter (CNT_WIDTH, clk, rst_n, inc -> count), instantiated twice for the stall counters.
- Arbiter, output register and forwarding stay in regfile_wb_arbiter.

Test Plan:
- Reset: hold rst_n=0 with both valid -> ready=0/0, we3=0, stall counters 0. Release -> next cycle req0 granted (prio=0).
- Single requester: req1 valid addr=7 data=0xDEAD for one cycle -> req1_ready=1; next cycle we3=1, wa3=7, wd3=0xDEAD; following cycle we3=0.
- Contention: both valid for 4 cycles with distinct addrs (0: r3, 1: r9) -> grants alternate 0,1,0,1. stall_cnt0 and stall_cnt1 each read 2 after the burst (req0 stalls in cycles 2 and 4, req1 in cycles 1 and 3).
- x0 write: req0 valid addr=0 data=0x55 -> req0_ready=1; next cycle we3=0. With ra1=0: hazard1=0 and rd1=rd1_regfile.
- Forwarding: accept req0 addr=5 data=0x1234 with ra1=ra2=5 and rd*_regfile=0x5 -> next cycle hazard1=hazard2=1, rd1=rd2=0x1234. The cycle after that, hazards are 0.
- Reset mid-flight and saturation: reset asserted while we3=1 -> we3=0 after the edge. Preload or force stall_cnt0 to all-ones, keep req0 stalled -> the counter stays all-ones.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the regfile writeback path.
package regfile_pkg;

  localparam int BANK_WIDTH = 5;
  localparam int WIDTH      = 64;

  localparam logic [BANK_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [BANK_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU and load
// writeback, with read-port forwarding from the in-flight write.
module regfile_wb_arbiter
  import regfile_pkg::REG_ZERO;
#(
  parameter int BANK_WIDTH = 5,
  parameter int WIDTH      = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [BANK_WIDTH-1:0] req0_addr,
  input  logic [WIDTH-1:0]      req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [BANK_WIDTH-1:0] req1_addr,
  input  logic [WIDTH-1:0]      req1_data,
  output logic                  req1_ready,
  output logic [BANK_WIDTH-1:0] wa3,
  output logic [WIDTH-1:0]      wd3,
  output logic                  we3,
  input  logic [BANK_WIDTH-1:0] ra1,
  input  logic [BANK_WIDTH-1:0] ra2,
  input  logic [WIDTH-1:0]      rd1_regfile,
  input  logic [WIDTH-1:0]      rd2_regfile,
  output logic [WIDTH-1:0]      rd1,
  output logic [WIDTH-1:0]      rd2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic [CNT_WIDTH-1:0]  stall_cnt0,
  output logic [CNT_WIDTH-1:0]  stall_cnt1
);

  localparam logic [BANK_WIDTH-1:0] ZERO_ADDR = BANK_WIDTH'(REG_ZERO);

  logic                  prio_q, prio_d;
  logic                  we3_q, we3_d;
  logic [BANK_WIDTH-1:0] wa3_q, wa3_d;
  logic [WIDTH-1:0]      wd3_q, wd3_d;

  logic                  grant0, grant1, xfer;
  logic [BANK_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_data;

  // prio=1 means req1 wins a tie; the output stage never back-pressures.
  assign grant0 = rst_n && req0_valid && (!req1_valid || !prio_q);
  assign grant1 = rst_n && req1_valid && (!req0_valid ||  prio_q);
  assign xfer   = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sel_addr = grant1 ? req1_addr : req0_addr;
  assign sel_data = grant1 ? req1_data : req0_data;

  always_comb begin
    prio_d = prio_q;
    we3_d  = 1'b0;
    wa3_d  = wa3_q;
    wd3_d  = wd3_q;
    if (xfer) begin
      prio_d = grant0;
      we3_d  = (sel_addr != ZERO_ADDR);
      wa3_d  = sel_addr;
      wd3_d  = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
      we3_q  <= 1'b0;
      wa3_q  <= '0;
      wd3_q  <= '0;
    end else begin
      prio_q <= prio_d;
      we3_q  <= we3_d;
      wa3_q  <= wa3_d;
      wd3_q  <= wd3_d;
    end
  end

  assign we3 = we3_q;
  assign wa3 = wa3_q;
  assign wd3 = wd3_q;

  assign hazard1 = we3_q && (wa3_q == ra1) && (ra1 != ZERO_ADDR);
  assign hazard2 = we3_q && (wa3_q == ra2) && (ra2 != ZERO_ADDR);
  assign rd1     = hazard1 ? wd3_q : rd1_regfile;
  assign rd2     = hazard2 ? wd3_q : rd2_regfile;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall0 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (req0_valid && !req0_ready),
    .count (stall_cnt0)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall1 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (req1_valid && !req1_ready),
    .count (stall_cnt1)
  );

endmodule
